branch_tag_ctrl: RTL and testbench

- Allocates, tracks and retires speculative branch tags for the frontend and backend.
- Sits between decode (one tag allocated per predicted branch) and branch resolution (clean or kill).
- Tracks which in-flight tags depend on which, so a mispredict squashes the mispredicted tag and every younger tag.
- Drives the registered clean/kill broadcast and flush, and stalls decode when no tag is free.

---
 rtl/branch_tag_ctrl.sv | 123 ++++++++++++
 tb/tb_branch_tag_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_tag_ctrl.sv
// Speculative branch tag allocator: hands out tags to decode, tracks tag-to-tag
// dependencies, and broadcasts clean/kill resolutions with a squash mask and flush.
module branch_tag_ctrl #(
    parameter  int NUM_TAGS = 4,
    localparam int TAG_W    = $clog2(NUM_TAGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                alloc_req,
    output logic                alloc_gnt,
    output logic [TAG_W-1:0]    alloc_tag,
    output logic [NUM_TAGS-1:0] cur_mask,
    output logic                tag_stall,
    input  logic                br_resolved,
    input  logic [TAG_W-1:0]    br_tag,
    input  logic                mispredict,
    output logic                bc_valid,
    output logic                bc_clean,
    output logic                bc_kill,
    output logic [TAG_W-1:0]    bc_tag,
    output logic [NUM_TAGS-1:0] kill_mask,
    output logic                flush,
    output logic [TAG_W:0]      free_count
);

    logic [NUM_TAGS-1:0] r_busy;
    logic [NUM_TAGS-1:0] r_dep [NUM_TAGS];

    logic                w_clean;
    logic                w_kill;
    logic                w_tag_live;
    logic [NUM_TAGS-1:0] w_br_onehot;
    logic [NUM_TAGS-1:0] w_clean_bit;
    logic [NUM_TAGS-1:0] w_kill_set;
    logic [NUM_TAGS-1:0] w_busy_nxt;
    logic [NUM_TAGS-1:0] w_dep_nxt [NUM_TAGS];
    logic [TAG_W:0]      w_free_nxt;
    logic [TAG_W-1:0]    w_free_tag;

    assign w_clean     = br_resolved & ~mispredict;
    assign w_kill      = br_resolved & mispredict;
    assign w_tag_live  = r_busy[br_tag];
    assign w_br_onehot = {{(NUM_TAGS-1){1'b0}}, 1'b1} << br_tag;
    assign w_clean_bit = w_clean ? w_br_onehot : '0;

    // Allocation looks only at the registered busy vector, so a tag freed this
    // cycle cannot be handed out again until the next one.
    always_comb begin
        w_free_tag = '0;
        for (int i = NUM_TAGS - 1; i >= 0; i--) begin
            if (!r_busy[i]) w_free_tag = TAG_W'(i);
        end
    end

    assign alloc_gnt = alloc_req & ~(&r_busy) & ~w_kill;
    assign alloc_tag = w_free_tag;
    assign cur_mask  = r_busy & ~w_clean_bit;
    assign tag_stall = alloc_req & ~alloc_gnt;

    // Squash set: the mispredicted tag plus every tag allocated while it was live.
    always_comb begin
        w_kill_set = w_br_onehot;
        if (w_tag_live) begin
            for (int j = 0; j < NUM_TAGS; j++) begin
                if (r_dep[j][br_tag]) w_kill_set[j] = 1'b1;
            end
        end
    end

    always_comb begin
        w_busy_nxt = r_busy;
        for (int j = 0; j < NUM_TAGS; j++) w_dep_nxt[j] = r_dep[j];

        if (w_kill && w_tag_live) begin
            w_busy_nxt = r_busy & ~w_kill_set;
            for (int j = 0; j < NUM_TAGS; j++) begin
                if (w_kill_set[j]) w_dep_nxt[j] = '0;
                else               w_dep_nxt[j] = r_dep[j] & ~w_kill_set;
            end
        end else if (w_clean && w_tag_live) begin
            w_busy_nxt[br_tag] = 1'b0;
            for (int j = 0; j < NUM_TAGS; j++) w_dep_nxt[j][br_tag] = 1'b0;
        end

        // Grant never coincides with a kill; with a clean it takes a different tag.
        if (alloc_gnt) begin
            w_busy_nxt[w_free_tag] = 1'b1;
            w_dep_nxt[w_free_tag]  = cur_mask;
        end
    end

    always_comb begin
        w_free_nxt = '0;
        for (int j = 0; j < NUM_TAGS; j++) begin
            if (!w_busy_nxt[j]) w_free_nxt = w_free_nxt + {{TAG_W{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy     <= '0;
            for (int j = 0; j < NUM_TAGS; j++) r_dep[j] <= '0;
            bc_valid   <= 1'b0;
            bc_clean   <= 1'b0;
            bc_kill    <= 1'b0;
            bc_tag     <= '0;
            kill_mask  <= '0;
            flush      <= 1'b0;
            free_count <= (TAG_W+1)'(NUM_TAGS);
        end else begin
            r_busy     <= w_busy_nxt;
            for (int j = 0; j < NUM_TAGS; j++) r_dep[j] <= w_dep_nxt[j];
            bc_valid   <= br_resolved;
            bc_clean   <= w_clean;
            bc_kill    <= w_kill;
            bc_tag     <= br_tag;
            kill_mask  <= w_kill ? w_kill_set : '0;
            flush      <= w_kill;
            free_count <= w_free_nxt;
        end
    end

endmodule

// File: tb/tb_branch_tag_ctrl.sv
// Directed bench for branch_tag_ctrl with NUM_TAGS=4: allocation order, clean,
// kill squash masks, same-cycle clean/alloc, reset during a kill, back-to-back resolves.
module tb_branch_tag_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       alloc_req = 1'b0;
    logic       alloc_gnt;
    logic [1:0] alloc_tag;
    logic [3:0] cur_mask;
    logic       tag_stall;
    logic       br_resolved = 1'b0;
    logic [1:0] br_tag = 2'd0;
    logic       mispredict = 1'b0;
    logic       bc_valid;
    logic       bc_clean;
    logic       bc_kill;
    logic [1:0] bc_tag;
    logic [3:0] kill_mask;
    logic       flush;
    logic [2:0] free_count;

    int n_pass  = 0;
    int n_total = 0;

    branch_tag_ctrl #(.NUM_TAGS(4)) dut (
        .clk(clk), .rst(rst),
        .alloc_req(alloc_req), .alloc_gnt(alloc_gnt), .alloc_tag(alloc_tag),
        .cur_mask(cur_mask), .tag_stall(tag_stall),
        .br_resolved(br_resolved), .br_tag(br_tag), .mispredict(mispredict),
        .bc_valid(bc_valid), .bc_clean(bc_clean), .bc_kill(bc_kill), .bc_tag(bc_tag),
        .kill_mask(kill_mask), .flush(flush), .free_count(free_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alloc_req   = 1'b0;
        br_resolved = 1'b0;
        mispredict  = 1'b0;
        br_tag      = 2'd0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic fill(input int n);
        alloc_req = 1'b1;
        for (int i = 0; i < n; i++) step();
        alloc_req = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_total++; if (bc_valid !== 1'b0) $display("FAIL reset_bc_valid got %0d want 0", bc_valid); else n_pass++;
        n_total++; if (bc_kill !== 1'b0) $display("FAIL reset_bc_kill got %0d want 0", bc_kill); else n_pass++;
        n_total++; if (flush !== 1'b0) $display("FAIL reset_flush got %0d want 0", flush); else n_pass++;
        n_total++; if (kill_mask !== 4'b0000) $display("FAIL reset_kill_mask got %b want 0000", kill_mask); else n_pass++;
        n_total++; if (free_count !== 3'd4) $display("FAIL reset_free_count got %0d want 4", free_count); else n_pass++;
    endtask

    task automatic test_fill();
        logic [3:0] exp_mask [4];
        exp_mask[0] = 4'b0000; exp_mask[1] = 4'b0001; exp_mask[2] = 4'b0011; exp_mask[3] = 4'b0111;
        alloc_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_total++; if (alloc_gnt !== 1'b1) $display("FAIL fill_gnt[%0d] got %0d want 1", i, alloc_gnt); else n_pass++;
            n_total++; if (alloc_tag !== 2'(i)) $display("FAIL fill_tag[%0d] got %0d want %0d", i, alloc_tag, i); else n_pass++;
            n_total++; if (cur_mask !== exp_mask[i]) $display("FAIL fill_mask[%0d] got %b want %b", i, cur_mask, exp_mask[i]); else n_pass++;
            step();
        end
        #1;
        n_total++; if (tag_stall !== 1'b1) $display("FAIL full_stall got %0d want 1", tag_stall); else n_pass++;
        n_total++; if (alloc_gnt !== 1'b0) $display("FAIL full_gnt got %0d want 0", alloc_gnt); else n_pass++;
        n_total++; if (free_count !== 3'd0) $display("FAIL full_free_count got %0d want 0", free_count); else n_pass++;
        alloc_req = 1'b0;
    endtask

    task automatic test_clean();
        br_resolved = 1'b1; br_tag = 2'd1; mispredict = 1'b0;
        #1;
        n_total++; if (cur_mask !== 4'b1101) $display("FAIL clean_cur_mask got %b want 1101", cur_mask); else n_pass++;
        step();
        idle_inputs();
        alloc_req = 1'b1;
        #1;
        n_total++; if (bc_valid !== 1'b1) $display("FAIL clean_bc_valid got %0d want 1", bc_valid); else n_pass++;
        n_total++; if (bc_clean !== 1'b1) $display("FAIL clean_bc_clean got %0d want 1", bc_clean); else n_pass++;
        n_total++; if (bc_kill !== 1'b0) $display("FAIL clean_bc_kill got %0d want 0", bc_kill); else n_pass++;
        n_total++; if (bc_tag !== 2'd1) $display("FAIL clean_bc_tag got %0d want 1", bc_tag); else n_pass++;
        n_total++; if (free_count !== 3'd1) $display("FAIL clean_free_count got %0d want 1", free_count); else n_pass++;
        n_total++; if (flush !== 1'b0) $display("FAIL clean_flush got %0d want 0", flush); else n_pass++;
        n_total++; if (alloc_tag !== 2'd1) $display("FAIL clean_realloc_tag got %0d want 1", alloc_tag); else n_pass++;
        n_total++; if (cur_mask !== 4'b1101) $display("FAIL clean_realloc_mask got %b want 1101", cur_mask); else n_pass++;
        step();
        alloc_req = 1'b0;
        // Tags 2 and 3 must no longer depend on tag 1, so killing the new tag 1 squashes only itself.
        br_resolved = 1'b1; br_tag = 2'd1; mispredict = 1'b1;
        step();
        idle_inputs();
        #1;
        n_total++; if (kill_mask !== 4'b0010) $display("FAIL dep_col_cleared_kill_mask got %b want 0010", kill_mask); else n_pass++;
        n_total++; if (free_count !== 3'd1) $display("FAIL dep_col_cleared_free got %0d want 1", free_count); else n_pass++;
    endtask

    task automatic test_kill();
        do_reset();
        fill(4);
        br_resolved = 1'b1; br_tag = 2'd1; mispredict = 1'b1; alloc_req = 1'b1;
        #1;
        n_total++; if (alloc_gnt !== 1'b0) $display("FAIL kill_full_gnt got %0d want 0", alloc_gnt); else n_pass++;
        step();
        idle_inputs();
        #1;
        n_total++; if (bc_kill !== 1'b1) $display("FAIL kill_bc_kill got %0d want 1", bc_kill); else n_pass++;
        n_total++; if (bc_clean !== 1'b0) $display("FAIL kill_bc_clean got %0d want 0", bc_clean); else n_pass++;
        n_total++; if (bc_tag !== 2'd1) $display("FAIL kill_bc_tag got %0d want 1", bc_tag); else n_pass++;
        n_total++; if (kill_mask !== 4'b1110) $display("FAIL kill_mask got %b want 1110", kill_mask); else n_pass++;
        n_total++; if (flush !== 1'b1) $display("FAIL kill_flush got %0d want 1", flush); else n_pass++;
        n_total++; if (free_count !== 3'd3) $display("FAIL kill_free_count got %0d want 3", free_count); else n_pass++;
        alloc_req = 1'b1;
        #1;
        n_total++; if (alloc_tag !== 2'd1) $display("FAIL kill_next_tag got %0d want 1", alloc_tag); else n_pass++;
        n_total++; if (cur_mask !== 4'b0001) $display("FAIL kill_next_mask got %b want 0001", cur_mask); else n_pass++;
        // Kill of tag 0 with free tags and a pending request: kill wins, nothing granted.
        br_resolved = 1'b1; br_tag = 2'd0; mispredict = 1'b1;
        #1;
        n_total++; if (alloc_gnt !== 1'b0) $display("FAIL kill_priority_gnt got %0d want 0", alloc_gnt); else n_pass++;
        n_total++; if (tag_stall !== 1'b1) $display("FAIL kill_priority_stall got %0d want 1", tag_stall); else n_pass++;
        step();
        idle_inputs();
        #1;
        n_total++; if (flush !== 1'b1) $display("FAIL kill2_flush got %0d want 1", flush); else n_pass++;
        n_total++; if (kill_mask !== 4'b0001) $display("FAIL kill2_mask got %b want 0001", kill_mask); else n_pass++;
        n_total++; if (free_count !== 3'd4) $display("FAIL kill2_free_count got %0d want 4", free_count); else n_pass++;
        step();
        n_total++; if (flush !== 1'b0) $display("FAIL flush_one_cycle got %0d want 0", flush); else n_pass++;
        n_total++; if (kill_mask !== 4'b0000) $display("FAIL kill_mask_idle got %b want 0000", kill_mask); else n_pass++;
    endtask

    task automatic test_clean_alloc_same();
        do_reset();
        fill(2);
        br_resolved = 1'b1; br_tag = 2'd0; mispredict = 1'b0; alloc_req = 1'b1;
        #1;
        n_total++; if (alloc_gnt !== 1'b1) $display("FAIL same_gnt got %0d want 1", alloc_gnt); else n_pass++;
        n_total++; if (alloc_tag !== 2'd2) $display("FAIL same_tag got %0d want 2", alloc_tag); else n_pass++;
        n_total++; if (cur_mask !== 4'b0010) $display("FAIL same_mask got %b want 0010", cur_mask); else n_pass++;
        step();
        br_resolved = 1'b0;
        #1;
        n_total++; if (alloc_tag !== 2'd0) $display("FAIL same_next_tag got %0d want 0", alloc_tag); else n_pass++;
        n_total++; if (cur_mask !== 4'b0110) $display("FAIL same_next_mask got %b want 0110", cur_mask); else n_pass++;
        n_total++; if (free_count !== 3'd2) $display("FAIL same_free_count got %0d want 2", free_count); else n_pass++;
        step();
        idle_inputs();
        #1;
        n_total++; if (free_count !== 3'd1) $display("FAIL same_after_free got %0d want 1", free_count); else n_pass++;
    endtask

    task automatic test_kill_oldest();
        do_reset();
        fill(4);
        br_resolved = 1'b1; br_tag = 2'd0; mispredict = 1'b1;
        step();
        idle_inputs();
        alloc_req = 1'b1;
        #1;
        n_total++; if (kill_mask !== 4'b1111) $display("FAIL oldest_kill_mask got %b want 1111", kill_mask); else n_pass++;
        n_total++; if (free_count !== 3'd4) $display("FAIL oldest_free_count got %0d want 4", free_count); else n_pass++;
        n_total++; if (alloc_tag !== 2'd0) $display("FAIL oldest_next_tag got %0d want 0", alloc_tag); else n_pass++;
        n_total++; if (cur_mask !== 4'b0000) $display("FAIL oldest_next_mask got %b want 0000", cur_mask); else n_pass++;
        step();
        alloc_req = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        fill(2);
        br_resolved = 1'b1; br_tag = 2'd0; mispredict = 1'b1; rst = 1'b1;
        step();
        rst = 1'b0;
        idle_inputs();
        alloc_req = 1'b1;
        #1;
        n_total++; if (flush !== 1'b0) $display("FAIL rstmid_flush got %0d want 0", flush); else n_pass++;
        n_total++; if (bc_valid !== 1'b0) $display("FAIL rstmid_bc_valid got %0d want 0", bc_valid); else n_pass++;
        n_total++; if (kill_mask !== 4'b0000) $display("FAIL rstmid_kill_mask got %b want 0000", kill_mask); else n_pass++;
        n_total++; if (free_count !== 3'd4) $display("FAIL rstmid_free_count got %0d want 4", free_count); else n_pass++;
        n_total++; if (cur_mask !== 4'b0000) $display("FAIL rstmid_cur_mask got %b want 0000", cur_mask); else n_pass++;
        step();
        alloc_req = 1'b0;
    endtask

    task automatic test_back_to_back();
        do_reset();
        fill(3);
        br_resolved = 1'b1; br_tag = 2'd2; mispredict = 1'b0;
        step();
        br_tag = 2'd0;
        #1;
        n_total++; if (bc_tag !== 2'd2) $display("FAIL b2b_first_tag got %0d want 2", bc_tag); else n_pass++;
        n_total++; if (free_count !== 3'd2) $display("FAIL b2b_first_free got %0d want 2", free_count); else n_pass++;
        step();
        br_tag = 2'd3;
        #1;
        n_total++; if (bc_tag !== 2'd0) $display("FAIL b2b_second_tag got %0d want 0", bc_tag); else n_pass++;
        n_total++; if (bc_clean !== 1'b1) $display("FAIL b2b_second_clean got %0d want 1", bc_clean); else n_pass++;
        n_total++; if (free_count !== 3'd3) $display("FAIL b2b_second_free got %0d want 3", free_count); else n_pass++;
        $display("WARN resolving non-busy tag 3 (squash-race case)");
        step();
        br_tag = 2'd3; mispredict = 1'b1;
        #1;
        n_total++; if (bc_valid !== 1'b1) $display("FAIL stale_clean_valid got %0d want 1", bc_valid); else n_pass++;
        n_total++; if (free_count !== 3'd3) $display("FAIL stale_clean_free got %0d want 3", free_count); else n_pass++;
        step();
        idle_inputs();
        alloc_req = 1'b1;
        #1;
        n_total++; if (kill_mask !== 4'b1000) $display("FAIL stale_kill_mask got %b want 1000", kill_mask); else n_pass++;
        n_total++; if (free_count !== 3'd3) $display("FAIL stale_kill_free got %0d want 3", free_count); else n_pass++;
        n_total++; if (cur_mask !== 4'b0010) $display("FAIL stale_kill_busy got %b want 0010", cur_mask); else n_pass++;
        step();
        alloc_req = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fill();
        test_clean();
        test_kill();
        test_clean_alloc_same();
        test_kill_oldest();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
